// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_pkg
// Description : Shared types and constants for the ADC sample scheduler:
//               FSM state encoding, conversion-owner codes and the default
//               conversion timeout.
// Revision    : 1.0  initial release
// ============================================================================
package adc_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CONV  = 2'd2
    } state_e;

    // Which requester owns the conversion in flight
    typedef enum logic {
        OWN_PULSE = 1'b0,
        OWN_CW    = 1'b1
    } owner_e;

    // Default maximum conv_start -> conv_done wait, in clk cycles
    localparam int TIMEOUT_DEFAULT = 255;

endpackage : adc_sched_pkg
`default_nettype wire

// File: rtl/adc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_if
// Description : Conversion handshake between the scheduler and the serial
//               ADC engine.
//               conv_start : one-cycle start strobe   (scheduler -> ADC)
//               conv_done  : one-cycle done strobe    (ADC -> scheduler)
//               conv_data  : result, valid with conv_done (ADC -> scheduler)
//               Modports: master = scheduler side, slave = ADC engine side.
// Revision    : 1.0  initial release
// ============================================================================
interface adc_sched_if #(
    parameter int DATA_W = 16
);
    logic              conv_start;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;

    modport master (
        output conv_start,
        input  conv_done,
        input  conv_data
    );

    modport slave (
        input  conv_start,
        output conv_done,
        output conv_data
    );
endinterface : adc_sched_if
`default_nettype wire

// File: rtl/adc_sched_delay.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_delay
// Description : Loadable down-counter timing the gap between a laser pulse
//               edge and its sample request.
// Ports       : clk, rst   clock / synchronous active-high reset
//               clr_i      clear and hold the counter at 0
//               load_i     load value_i (only asserted while not busy)
//               value_i    delay in clk cycles
//               busy_o     counter running (non-zero)
//               expire_o   one-cycle strobe when the delay has elapsed;
//                          a zero load expires in the load cycle itself
// Revision    : 1.0  initial release
// ============================================================================
module adc_sched_delay #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr_i,
    input  wire logic         load_i,
    input  wire logic [W-1:0] value_i,
    output logic              busy_o,
    output logic              expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o   = (cnt_q != '0);
    // Expire on the 1->0 step so a delay of N yields the request N cycles
    // after the load edge; a zero delay expires alongside the load.
    assign expire_o = !clr_i && ((load_i && (value_i == '0)) ||
                                 (!load_i && (cnt_q == W'(1))));

endmodule : adc_sched_delay
`default_nettype wire

// File: rtl/adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_scheduler
// Description : Shares one serial ADC engine between pulse-synchronous
//               sampling (fixed delay after each laser_pulse rising edge)
//               and periodic CW monitor sampling. Issues one-cycle
//               conversion starts, tracks the owner, routes results to
//               per-requester outputs, and flags dropped pulse samples and
//               hung conversions.
// Ports       : clk, rst         clock / synchronous active-high reset
//               enable_i         scheduler enable
//               laser_pulse_i    asynchronous laser gate (2-FF synchronised)
//               pulse_delay_i    cycles from synced edge to pulse request
//               cw_period_i      CW sample interval in cycles, 0 = off
//               clear_i          clears sticky error flags
//               adc              conversion handshake (master modport)
//               pulse_sample_o / pulse_valid_o   last pulse result / strobe
//               cw_sample_o    / cw_valid_o      last CW result / strobe
//               overrun_o        sticky: pulse request dropped
//               timeout_err_o    sticky: conversion exceeded TIMEOUT_CYC
// Config      : ADC_SCHED_CW_AVG_EN - when defined, cw_sample_o is the mean
//               of the last four CW results and cw_valid_o stays low until
//               four CW results have arrived since reset / enable rise.
// Revision    : 1.0  initial release
// ============================================================================
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DLY_W       = 16,
    parameter int PER_W       = 24,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enable_i,
    input  wire logic              laser_pulse_i,
    input  wire logic [DLY_W-1:0]  pulse_delay_i,
    input  wire logic [PER_W-1:0]  cw_period_i,
    input  wire logic              clear_i,
    adc_sched_if.master            adc,
    output logic [DATA_W-1:0]      pulse_sample_o,
    output logic                   pulse_valid_o,
    output logic [DATA_W-1:0]      cw_sample_o,
    output logic                   cw_valid_o,
    output logic                   overrun_o,
    output logic                   timeout_err_o
);

    localparam int          TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // Laser pulse synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= laser_pulse_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    state_e            state_q;
    owner_e            owner_q;
    logic              conv_start_q;
    logic [TMR_W-1:0]  timer_q;
    logic              pulse_req_q;
    logic              cw_req_q;
    logic [PER_W-1:0]  cw_cnt_q;
    logic              overrun_q;
    logic              timeout_err_q;
    logic              pulse_valid_q;
    logic [DATA_W-1:0] pulse_sample_q;
    logic              cw_valid_q;
    logic [DATA_W-1:0] cw_sample_q;

    logic w_edge;
    logic w_pulse_busy;
    logic w_accept;
    logic w_drop;
    logic w_dly_busy;
    logic w_dly_expire;
    logic w_cw_wrap;
    logic w_grant;
    logic w_grant_pulse;
    logic w_grant_cw;
    logic w_cw_capture;

    assign w_edge = enable_i && sync2_q && !sync3_q;

    // A new edge is only accepted when the pulse path is completely free:
    // no delay running, no request waiting, no pulse conversion in flight.
    assign w_pulse_busy = w_dly_busy || pulse_req_q ||
                          ((state_q != ST_IDLE) && (owner_q == OWN_PULSE));
    assign w_accept     = w_edge && !w_pulse_busy;
    assign w_drop       = w_edge &&  w_pulse_busy;

    adc_sched_delay #(
        .W (DLY_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!enable_i),
        .load_i   (w_accept),
        .value_i  (pulse_delay_i),
        .busy_o   (w_dly_busy),
        .expire_o (w_dly_expire)
    );

    // ------------------------------------------------------------------
    // Request arbitration (pulse has priority over CW)
    // ------------------------------------------------------------------
    assign w_cw_wrap     = enable_i && (cw_period_i != '0) &&
                           (cw_cnt_q >= (cw_period_i - PER_W'(1)));
    assign w_grant       = (state_q == ST_IDLE) && enable_i &&
                           (pulse_req_q || cw_req_q);
    assign w_grant_pulse = w_grant &&  pulse_req_q;
    assign w_grant_cw    = w_grant && !pulse_req_q;
    assign w_cw_capture  = (state_q == ST_CONV) && adc.conv_done &&
                           (owner_q == OWN_CW);

    // Pending requests, CW interval counter and overrun flag. Setting a
    // request wins over clearing it on grant, so a CW wrap coinciding with
    // its own grant leaves a fresh request pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_req_q <= 1'b0;
            cw_req_q    <= 1'b0;
            cw_cnt_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (!enable_i) begin
                pulse_req_q <= 1'b0;
            end else if (w_dly_expire) begin
                pulse_req_q <= 1'b1;
            end else if (w_grant_pulse) begin
                pulse_req_q <= 1'b0;
            end

            if (!enable_i) begin
                cw_req_q <= 1'b0;
            end else if (w_cw_wrap) begin
                cw_req_q <= 1'b1;
            end else if (w_grant_cw) begin
                cw_req_q <= 1'b0;
            end

            if (!enable_i || (cw_period_i == '0) || w_cw_wrap) begin
                cw_cnt_q <= '0;
            end else begin
                cw_cnt_q <= cw_cnt_q + PER_W'(1);
            end

            if (w_drop) begin
                overrun_q <= 1'b1;
            end else if (clear_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_PULSE;
            conv_start_q   <= 1'b0;
            timer_q        <= '0;
            timeout_err_q  <= 1'b0;
            pulse_valid_q  <= 1'b0;
            pulse_sample_q <= '0;
        end else begin
            conv_start_q  <= 1'b0;
            pulse_valid_q <= 1'b0;
            if (clear_i) begin
                timeout_err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_grant) begin
                        state_q      <= ST_ISSUE;
                        conv_start_q <= 1'b1;
                        owner_q      <= pulse_req_q ? OWN_PULSE : OWN_CW;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_CONV;
                    timer_q <= '0;
                end
                ST_CONV: begin
                    if (adc.conv_done) begin
                        state_q <= ST_IDLE;
                        if (owner_q == OWN_PULSE) begin
                            pulse_sample_q <= adc.conv_data;
                            pulse_valid_q  <= 1'b1;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        // Set after the clear above so a coincident
                        // clear loses to the new error.
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CW result path
    // ------------------------------------------------------------------
`ifdef ADC_SCHED_CW_AVG_EN
    logic [DATA_W-1:0] hist0_q, hist1_q, hist2_q;
    logic [1:0]        avg_cnt_q;
    logic              en_dly_q;
    logic              w_en_rise;
    logic [DATA_W+1:0] w_sum;

    assign w_en_rise = enable_i && !en_dly_q;
    assign w_sum     = {2'b00, adc.conv_data} + {2'b00, hist0_q} +
                       {2'b00, hist1_q}       + {2'b00, hist2_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            hist0_q     <= '0;
            hist1_q     <= '0;
            hist2_q     <= '0;
            avg_cnt_q   <= 2'd0;
            en_dly_q    <= 1'b0;
            cw_valid_q  <= 1'b0;
            cw_sample_q <= '0;
        end else begin
            en_dly_q   <= enable_i;
            cw_valid_q <= 1'b0;
            if (w_cw_capture) begin
                hist0_q <= adc.conv_data;
                hist1_q <= hist0_q;
                hist2_q <= hist1_q;
            end
            // avg_cnt_q == 3 means three results are already in the
            // history, so this capture completes a full window of four.
            if (w_en_rise) begin
                avg_cnt_q <= 2'd0;
            end else if (w_cw_capture) begin
                if (avg_cnt_q == 2'd3) begin
                    cw_sample_q <= w_sum[DATA_W+1:2];
                    cw_valid_q  <= 1'b1;
                end else begin
                    avg_cnt_q <= avg_cnt_q + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cw_valid_q  <= 1'b0;
            cw_sample_q <= '0;
        end else begin
            cw_valid_q <= 1'b0;
            if (w_cw_capture) begin
                cw_sample_q <= adc.conv_data;
                cw_valid_q  <= 1'b1;
            end
        end
    end
`endif

    assign adc.conv_start = conv_start_q;
    assign pulse_sample_o = pulse_sample_q;
    assign pulse_valid_o  = pulse_valid_q;
    assign cw_sample_o    = cw_sample_q;
    assign cw_valid_o     = cw_valid_q;
    assign overrun_o      = overrun_q;
    assign timeout_err_o  = timeout_err_q;

endmodule : adc_sample_scheduler
`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_scheduler
// Description : Directed self-checking bench for adc_sample_scheduler with
//               a behavioural ADC engine answering ADC_LAT cycles after
//               each conversion start (or never, when adc_hang is set).
//               Build with ADC_SCHED_CW_AVG_EN to exercise CW averaging.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_sample_scheduler;

    localparam int DATA_W  = 16;
    localparam int DLY_W   = 16;
    localparam int PER_W   = 24;
    localparam int ADC_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              laser_pulse;
    logic [DLY_W-1:0]  pulse_delay;
    logic [PER_W-1:0]  cw_period;
    logic              clear;
    logic [DATA_W-1:0] pulse_sample;
    logic              pulse_valid;
    logic [DATA_W-1:0] cw_sample;
    logic              cw_valid;
    logic              overrun;
    logic              timeout_err;

    adc_sched_if #(.DATA_W(DATA_W)) ifc ();

    adc_sample_scheduler #(
        .DATA_W      (DATA_W),
        .DLY_W       (DLY_W),
        .PER_W       (PER_W),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .laser_pulse_i  (laser_pulse),
        .pulse_delay_i  (pulse_delay),
        .cw_period_i    (cw_period),
        .clear_i        (clear),
        .adc            (ifc),
        .pulse_sample_o (pulse_sample),
        .pulse_valid_o  (pulse_valid),
        .cw_sample_o    (cw_sample),
        .cw_valid_o     (cw_valid),
        .overrun_o      (overrun),
        .timeout_err_o  (timeout_err)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;   // number of rising clk edges so far
    int          n_starts = 0;
    int          n_pv     = 0;
    bit          adc_hang = 1'b0;
    logic [15:0] adc_data = 16'h0000;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Event counters, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (ifc.conv_start === 1'b1) n_starts = n_starts + 1;
        if (pulse_valid === 1'b1)    n_pv     = n_pv + 1;
    end

    // ADC engine model
    initial begin
        ifc.conv_done = 1'b0;
        ifc.conv_data = '0;
        forever begin
            @(negedge clk);
            if (ifc.conv_start === 1'b1 && !adc_hang) begin
                repeat (ADC_LAT) @(negedge clk);
                ifc.conv_done = 1'b1;
                ifc.conv_data = adc_data;
                @(negedge clk);
                ifc.conv_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // Enable low clears pending requests and counters (and the CW average
    // window), giving each scenario a clean start.
    task automatic quiesce();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; laser_pulse = 1'b0; clear = 1'b0;
        pulse_delay = '0; cw_period = '0;
        repeat (3) step();
        checks++; if (ifc.conv_start !== 1'b0) begin failures++; $display("FAIL rst_conv_start: got %b want 0", ifc.conv_start); end
        checks++; if (pulse_valid !== 1'b0) begin failures++; $display("FAIL rst_pulse_valid: got %b want 0", pulse_valid); end
        checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL rst_cw_valid: got %b want 0", cw_valid); end
        checks++; if (pulse_sample !== 16'h0000) begin failures++; $display("FAIL rst_pulse_sample: got %h want 0000", pulse_sample); end
        checks++; if (cw_sample !== 16'h0000) begin failures++; $display("FAIL rst_cw_sample: got %h want 0000", cw_sample); end
        checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_flags: got ovr=%b to=%b want 0 0", overrun, timeout_err); end
        rst = 1'b0;
        enable = 1'b1;
        repeat (20) step();
        checks++; if (n_starts != 0) begin failures++; $display("FAIL idle_no_start: got %0d starts want 0", n_starts); end
    endtask

    // Raw edge sampled at the next rising edge; 2 sync + 10 delay + 1 grant
    // puts conv_start 13 edges after that, result strobe 1 after conv_done.
    task automatic test_pulse_delay();
        int t;
        quiesce();
        pulse_delay = 16'd10;
        adc_data    = 16'hA5C3;
        t = cyc;
        laser_pulse = 1'b1;
        wait_until(t + 5);  laser_pulse = 1'b0;
        wait_until(t + 13);
        checks++; if (ifc.conv_start !== 1'b0) begin failures++; $display("FAIL t1_start_early: got %b want 0", ifc.conv_start); end
        step();
        checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t1_start: got %b want 1", ifc.conv_start); end
        wait_until(t + 14 + ADC_LAT + 1);
        checks++; if (pulse_valid !== 1'b1 || pulse_sample !== 16'hA5C3) begin failures++; $display("FAIL t1_pulse_result: got v=%b d=%h want v=1 d=a5c3", pulse_valid, pulse_sample); end
        step();
        checks++; if (pulse_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_width: got %b want 0", pulse_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t1_overrun: got %b want 0", overrun); end
    endtask

    // CW counter wraps every 100 edges; first request after 100 edges,
    // start one edge later.
    task automatic test_cw_periodic();
        int base;
        quiesce();
        base = cyc;
        cw_period = 24'd100;
        for (int k = 0; k < 3; k++) begin
            adc_data = 16'h0100 + 16'(k) * 16'h0111;
            wait_until(base + 100 + 100 * k);
            checks++; if (ifc.conv_start !== 1'b0) begin failures++; $display("FAIL t2_start_early[%0d]: got %b want 0", k, ifc.conv_start); end
            step();
            checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t2_start[%0d]: got %b want 1", k, ifc.conv_start); end
            wait_until(base + 101 + 100 * k + ADC_LAT + 1);
`ifndef ADC_SCHED_CW_AVG_EN
            checks++; if (cw_valid !== 1'b1 || cw_sample !== adc_data) begin failures++; $display("FAIL t2_cw_result[%0d]: got v=%b d=%h want v=1 d=%h", k, cw_valid, cw_sample, adc_data); end
`else
            checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL t2_cw_suppressed[%0d]: got %b want 0", k, cw_valid); end
`endif
        end
        cw_period = '0;
    endtask

    // Pulse delay 37 and CW period 40 raise both requests on the same edge.
    task automatic test_simultaneous();
        int base;
        quiesce();
        adc_data    = 16'h1111;
        pulse_delay = 16'd37;
        base        = cyc;
        cw_period   = 24'd40;
        laser_pulse = 1'b1;
        wait_until(base + 5);  laser_pulse = 1'b0;
        wait_until(base + 40);
        checks++; if (ifc.conv_start !== 1'b0) begin failures++; $display("FAIL t3_start_early: got %b want 0", ifc.conv_start); end
        step();
        checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t3_pulse_start: got %b want 1", ifc.conv_start); end
        wait_until(base + 46);
        checks++; if (pulse_valid !== 1'b1 || pulse_sample !== 16'h1111) begin failures++; $display("FAIL t3_pulse_first: got v=%b d=%h want v=1 d=1111", pulse_valid, pulse_sample); end
        checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL t3_cw_not_first: got %b want 0", cw_valid); end
        adc_data = 16'h2222;
        step();
        checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t3_cw_start: got %b want 1", ifc.conv_start); end
        wait_until(base + 52);
`ifndef ADC_SCHED_CW_AVG_EN
        checks++; if (cw_valid !== 1'b1 || cw_sample !== 16'h2222) begin failures++; $display("FAIL t3_cw_result: got v=%b d=%h want v=1 d=2222", cw_valid, cw_sample); end
`else
        checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL t3_cw_suppressed: got %b want 0", cw_valid); end
`endif
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t3_overrun: got %b want 0", overrun); end
        cw_period = '0;
    endtask

    // Second edge lands inside the 50-cycle countdown and must be dropped.
    task automatic test_overrun();
        int base, s0, p0;
        quiesce();
        pulse_delay = 16'd50;
        adc_data    = 16'h0BAD;
        base = cyc; s0 = n_starts; p0 = n_pv;
        laser_pulse = 1'b1;
        wait_until(base + 5);   laser_pulse = 1'b0;
        wait_until(base + 10);  laser_pulse = 1'b1;
        wait_until(base + 12);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t4_overrun_early: got %b want 0", overrun); end
        step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t4_overrun_set: got %b want 1", overrun); end
        wait_until(base + 15);  laser_pulse = 1'b0;
        wait_until(base + 120);
        checks++; if (n_starts - s0 != 1) begin failures++; $display("FAIL t4_one_start: got %0d want 1", n_starts - s0); end
        checks++; if (n_pv - p0 != 1 || pulse_sample !== 16'h0BAD) begin failures++; $display("FAIL t4_one_result: got n=%0d d=%h want n=1 d=0bad", n_pv - p0, pulse_sample); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t4_overrun_sticky: got %b want 1", overrun); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t4_overrun_clear: got %b want 0", overrun); end
    endtask

    // Zero delay: start 4 edges after the raw edge; 255 CONV cycles later
    // the conversion is abandoned.
    task automatic test_timeout();
        int base, p0;
        quiesce();
        adc_hang    = 1'b1;
        pulse_delay = 16'd0;
        base = cyc; p0 = n_pv;
        laser_pulse = 1'b1;
        wait_until(base + 4);
        checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t5_start: got %b want 1", ifc.conv_start); end
        wait_until(base + 5);  laser_pulse = 1'b0;
        wait_until(base + 259);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL t5_timeout_early: got %b want 0", timeout_err); end
        step();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL t5_timeout_set: got %b want 1", timeout_err); end
        checks++; if (n_pv != p0) begin failures++; $display("FAIL t5_no_valid: got %0d strobes want 0", n_pv - p0); end
        adc_hang = 1'b0;
        adc_data = 16'h7E57;
        wait_until(base + 270);  laser_pulse = 1'b1;
        wait_until(base + 274);
        checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t5_next_start: got %b want 1", ifc.conv_start); end
        wait_until(base + 274 + ADC_LAT + 1);
        checks++; if (pulse_valid !== 1'b1 || pulse_sample !== 16'h7E57) begin failures++; $display("FAIL t5_next_result: got v=%b d=%h want v=1 d=7e57", pulse_valid, pulse_sample); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL t5_timeout_sticky: got %b want 1", timeout_err); end
        laser_pulse = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL t5_timeout_clear: got %b want 0", timeout_err); end
    endtask

`ifdef ADC_SCHED_CW_AVG_EN
    // Results 100,200,300,400: first strobe on the fourth, mean 250.
    task automatic test_cw_avg();
        quiesce();
        cw_period = 24'd50;
        for (int k = 0; k < 4; k++) begin
            int n;
            adc_data = 16'(100 * (k + 1));
            n = 0;
            while (ifc.conv_start !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            checks++; if (ifc.conv_start !== 1'b1) begin failures++; $display("FAIL t6_start_wait[%0d]: got no start within 200 cycles", k); end
            repeat (ADC_LAT + 1) step();
            checks++; if (cw_valid !== (k == 3)) begin failures++; $display("FAIL t6_cw_valid[%0d]: got %b want %b", k, cw_valid, (k == 3)); end
            if (k == 3) begin
                checks++; if (cw_sample !== 16'd250) begin failures++; $display("FAIL t6_cw_mean: got %0d want 250", cw_sample); end
            end
        end
        cw_period = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_pulse_delay();
        test_cw_periodic();
        test_simultaneous();
        test_overrun();
        test_timeout();
`ifdef ADC_SCHED_CW_AVG_EN
        test_cw_avg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adc_sample_scheduler
`default_nettype wire
